branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter UPD_DEPTH, default 2, SHALL set the number of predictor update buffer entries (power of two, at least 2).
REQ-003 Parameter CNT_W, default 32, SHALL set the performance counter width.
REQ-004 CLK  in  1  clock; all state SHALL change on its rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 mem_valid  in  1  memory stage holds a live (unsquashed) instruction.
REQ-007 mem_stall  in  1  pipeline frozen this cycle; the memory-stage instruction is not retiring.
REQ-008 BEQ, BNE  in  1 each  branch type from the pipeline latch; never both high.
REQ-009 zero  in  1  ALU zero flag for the memory-stage instruction.
REQ-010 pred_taken  in  1  taken prediction carried down from fetch.
REQ-011 pred_target  in  32  predicted target carried down from fetch.
REQ-012 PC_mem, NPC_mem  in  32 each  instruction PC and PC+4.
REQ-013 branch_target_mem  in  32  computed branch target.
REQ-014 branch_mispredict  out  1  flush request; combinational.
REQ-015 redirect_pc  out  32  correct next PC; meaningful only while branch_mispredict is high.
REQ-016 upd_valid  out  1  predictor update available.
REQ-017 upd_ready  in  1  predictor accepts the update.
REQ-018 upd_pc, upd_target  out  32 each  update key and target.
REQ-019 upd_taken  out  1  resolved direction.
REQ-020 branch_cnt, mispred_cnt  out  CNT_W each  performance counters.
REQ-021 drop_cnt  out  16  count of updates lost because the buffer was full.

Function
REQ-022 resolve SHALL equal mem_valid & ~mem_stall & (BEQ | BNE | pred_taken); each instruction therefore resolves exactly once, in its non-stalled cycle.
REQ-023 actual_taken SHALL equal (BEQ & zero) | (BNE & ~zero); it SHALL be 0 for a non-branch.
REQ-024 branch_mispredict SHALL equal resolve & ((actual_taken != pred_taken) | (actual_taken & pred_target != branch_target_mem)).
REQ-025 redirect_pc SHALL equal branch_target_mem when actual_taken is 1, and NPC_mem otherwise.
REQ-026 Non-branch with pred_taken=1 (predictor alias): branch_mispredict SHALL be 1, redirect_pc SHALL be NPC_mem, and an update with upd_taken=0 SHALL be enqueued.
REQ-027 Every resolve cycle SHALL enqueue {PC_mem, branch_target_mem, actual_taken} at the FIFO tail on the same clock edge.
REQ-028 The FIFO head SHALL drive upd_pc, upd_target and upd_taken; upd_valid SHALL equal ~empty.
REQ-029 A dequeue SHALL occur when upd_valid & upd_ready; head outputs SHALL remain stable while upd_valid & ~upd_ready.
REQ-030 Enqueue and dequeue in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is full (no drop).
REQ-031 An enqueue when full without a dequeue SHALL discard the new entry and increment drop_cnt; drop_cnt SHALL saturate at 16'hFFFF.
REQ-032 Read and write pointers SHALL wrap modulo UPD_DEPTH; full and empty SHALL be distinguished by an occupancy count or an extra pointer bit.
REQ-033 branch_cnt SHALL increment on resolve with (BEQ | BNE); mispred_cnt SHALL increment on branch_mispredict; both SHALL wrap modulo 2^CNT_W.
REQ-034 Update latency: an entry written at edge N SHALL be visible on upd_* after edge N if the FIFO was empty (one-cycle latency).

Reset
REQ-035 While RST is high, the FIFO SHALL be empty, upd_valid SHALL be 0, all counters SHALL be 0, and branch_mispredict SHALL be forced to 0.
REQ-036 RST asserted mid-operation SHALL discard all pending updates immediately, without waiting for a clock edge.

Verification
REQ-037 Correct BEQ prediction: BEQ=1, zero=1, pred_taken=1, pred_target=branch_target_mem=0x40 -> mispredict=0; update {PC, 0x40, 1} is enqueued; branch_cnt=1.
REQ-038 Wrong BNE prediction: BNE=1, zero=1, pred_taken=1, NPC_mem=0x104 -> mispredict=1, redirect_pc=0x104, mispred_cnt=1, upd_taken=0.
REQ-039 Wrong target: BEQ taken, pred_target=0x80, branch_target_mem=0x90 -> mispredict=1, redirect_pc=0x90.
REQ-040 Stalled branch held 3 cycles with mem_stall=1, then 1 cycle free -> exactly one resolve, branch_cnt=1, one FIFO entry.
REQ-041 upd_ready=0 with 3 resolves at UPD_DEPTH=2 -> upd_valid=1, first entry held at head, drop_cnt=1; a 4th resolve in the same cycle as upd_ready=1 -> no drop.
REQ-042 RST pulsed while the FIFO holds 2 entries and counters are nonzero -> upd_valid=0 and all counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Memory-stage branch resolution: detects mispredicts, queues predictor updates
// in a small FIFO with drop counting, and keeps branch/mispredict counters.
module branch_resolve_unit #(
  parameter int UPD_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             BEQ,
  input  logic             BNE,
  input  logic             zero,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [31:0]      PC_mem,
  input  logic [31:0]      NPC_mem,
  input  logic [31:0]      branch_target_mem,
  output logic             branch_mispredict,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int AW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(UPD_DEPTH);

  logic          resolve, actual_taken, is_branch;
  logic          full, empty, deq, wr, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] pc_mem  [UPD_DEPTH];
  logic [31:0] tgt_mem [UPD_DEPTH];
  logic        tkn_mem [UPD_DEPTH];

  assign is_branch    = BEQ | BNE;
  assign resolve      = mem_valid & ~mem_stall & (is_branch | pred_taken);
  assign actual_taken = (BEQ & zero) | (BNE & ~zero);

  // RST gates the flush so a stray request never escapes during reset.
  assign branch_mispredict = ~RST & resolve &
    ((actual_taken != pred_taken) | (actual_taken & (pred_target != branch_target_mem)));
  assign redirect_pc = actual_taken ? branch_target_mem : NPC_mem;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign upd_valid = ~empty;
  assign deq       = upd_valid & upd_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr        = resolve & (~full | deq);
  assign drop      = resolve & full & ~deq;

  assign upd_pc     = pc_mem[rd_ptr];
  assign upd_target = tgt_mem[rd_ptr];
  assign upd_taken  = tkn_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr) begin
      pc_mem[wr_ptr]  <= PC_mem;
      tgt_mem[wr_ptr] <= branch_target_mem;
      tkn_mem[wr_ptr] <= actual_taken;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (resolve & is_branch)          branch_cnt  <= branch_cnt + CNT_W'(1);
      if (branch_mispredict)            mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt    <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of single-cycle resolves plus
// hand sequences for stall, FIFO backpressure/drop and asynchronous reset.
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_valid, mem_stall, BEQ, BNE, zero, pred_taken;
  logic [31:0] pred_target, PC_mem, NPC_mem, branch_target_mem;
  logic        branch_mispredict;
  logic [31:0] redirect_pc;
  logic        upd_valid, upd_ready, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] branch_cnt, mispred_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.UPD_DEPTH(2), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .BEQ(BEQ), .BNE(BNE), .zero(zero), .pred_taken(pred_taken),
    .pred_target(pred_target), .PC_mem(PC_mem), .NPC_mem(NPC_mem),
    .branch_target_mem(branch_target_mem), .branch_mispredict(branch_mispredict),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v, s, beq, bne, z, pt;
    logic [31:0] ptgt, bt, npc;
    logic        e_misp, e_res, e_taken;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, s, beq, bne, z, pt,
                       input logic [31:0] ptgt, bt, pc, npc);
    mem_valid = v; mem_stall = s; BEQ = beq; BNE = bne; zero = z; pred_taken = pt;
    pred_target = ptgt; branch_target_mem = bt; PC_mem = pc; NPC_mem = npc;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    #2 RST = 1'b0;
  endtask

  int exp_br, exp_mp;

  initial begin
    //         v  s  beq bne z pt ptgt       bt         npc        misp res tkn redir
    vecs[0] = '{1, 0, 1, 0, 1, 1, 32'h40,  32'h40,  32'h104, 0, 1, 1, 32'h40};
    vecs[1] = '{1, 0, 0, 1, 1, 1, 32'h200, 32'h200, 32'h104, 1, 1, 0, 32'h104};
    vecs[2] = '{1, 0, 1, 0, 1, 1, 32'h80,  32'h90,  32'h124, 1, 1, 1, 32'h90};
    vecs[3] = '{1, 0, 0, 0, 0, 1, 32'h300, 32'h444, 32'h208, 1, 1, 0, 32'h208};
    vecs[4] = '{1, 0, 0, 1, 0, 0, 32'h0,   32'h500, 32'h144, 1, 1, 1, 32'h500};
    vecs[5] = '{1, 0, 1, 0, 0, 0, 32'h0,   32'h600, 32'h154, 0, 1, 0, 32'h154};
    vecs[6] = '{0, 0, 1, 0, 1, 0, 32'h0,   32'h700, 32'h164, 0, 0, 1, 32'h700};
    vecs[7] = '{1, 1, 0, 1, 0, 1, 32'h1,   32'h800, 32'h174, 0, 0, 1, 32'h800};
    vecs[8] = '{1, 0, 0, 0, 1, 0, 32'h0,   32'h900, 32'h184, 0, 0, 0, 32'h184};

    // Reset state, with a mispredicting instruction on the inputs.
    RST = 1'b1; upd_ready = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 32'h0, 32'h50, 32'h10, 32'h14);
    #1;
    chk("rst_misp", {31'b0, branch_mispredict}, 32'd0);
    chk("rst_upd_valid", {31'b0, upd_valid}, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    @(negedge CLK);
    idle();
    RST = 1'b0;

    exp_br = 0; exp_mp = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      drive(vecs[i].v, vecs[i].s, vecs[i].beq, vecs[i].bne, vecs[i].z, vecs[i].pt,
            vecs[i].ptgt, vecs[i].bt, 32'h1000 + 32'(i) * 32'h10, vecs[i].npc);
      #1;
      chk($sformatf("v%0d_misp", i), {31'b0, branch_mispredict}, {31'b0, vecs[i].e_misp});
      if (vecs[i].e_misp)
        chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].e_redir);
      @(posedge CLK);
      #1;
      if (vecs[i].e_res && (vecs[i].beq || vecs[i].bne)) exp_br++;
      if (vecs[i].e_misp) exp_mp++;
      chk($sformatf("v%0d_upd_valid", i), {31'b0, upd_valid}, {31'b0, vecs[i].e_res});
      if (vecs[i].e_res) begin
        chk($sformatf("v%0d_upd_pc", i), upd_pc, 32'h1000 + 32'(i) * 32'h10);
        chk($sformatf("v%0d_upd_target", i), upd_target, vecs[i].bt);
        chk($sformatf("v%0d_upd_taken", i), {31'b0, upd_taken}, {31'b0, vecs[i].e_taken});
      end
      chk($sformatf("v%0d_branch_cnt", i), branch_cnt, 32'(exp_br));
      chk($sformatf("v%0d_mispred_cnt", i), mispred_cnt, 32'(exp_mp));
    end

    // Stalled branch: three frozen cycles then one free cycle resolves once.
    pulse_reset();
    upd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1, 1, 1, 0, 1, 0, 32'h0, 32'h60, 32'h2000, 32'h2004);
      #1 chk($sformatf("stall%0d_misp", k), {31'b0, branch_mispredict}, 32'd0);
    end
    @(negedge CLK);
    mem_stall = 1'b0;
    #1;
    chk("stall_free_misp", {31'b0, branch_mispredict}, 32'd1);
    chk("stall_free_redirect", redirect_pc, 32'h60);
    @(negedge CLK);
    idle();
    chk("stall_branch_cnt", branch_cnt, 32'd1);
    chk("stall_mispred_cnt", mispred_cnt, 32'd1);
    chk("stall_upd_valid", {31'b0, upd_valid}, 32'd1);
    chk("stall_upd_pc", upd_pc, 32'h2000);
    chk("stall_upd_taken", {31'b0, upd_taken}, 32'd1);
    upd_ready = 1'b1;
    @(negedge CLK);
    chk("stall_one_entry", {31'b0, upd_valid}, 32'd0);

    // Backpressure: three resolves into a two-deep FIFO, then enqueue+dequeue when full.
    pulse_reset();
    upd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1, 0, 1, 0, 1, 1, 32'h40, 32'h40, 32'h3000 + 32'(k) * 32'h4, 32'h0);
    end
    @(negedge CLK);
    idle();
    chk("bp_upd_valid", {31'b0, upd_valid}, 32'd1);
    chk("bp_head_pc", upd_pc, 32'h3000);
    chk("bp_drop_cnt", {16'b0, drop_cnt}, 32'd1);
    @(negedge CLK);
    chk("bp_head_hold", upd_pc, 32'h3000);
    drive(1, 0, 1, 0, 1, 1, 32'h40, 32'h40, 32'h300C, 32'h0);
    upd_ready = 1'b1;
    @(negedge CLK);
    idle();
    chk("bp_full_no_drop", {16'b0, drop_cnt}, 32'd1);
    chk("bp_head_second", upd_pc, 32'h3004);
    @(negedge CLK);
    chk("bp_head_fourth", upd_pc, 32'h300C);
    chk("bp_fourth_valid", {31'b0, upd_valid}, 32'd1);
    @(negedge CLK);
    chk("bp_drained", {31'b0, upd_valid}, 32'd0);

    // Asynchronous reset with two pending updates and nonzero counters.
    upd_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      drive(1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h4000 + 32'(k) * 32'h4, 32'h4004);
    end
    @(negedge CLK);
    idle();
    chk("ar_pre_valid", {31'b0, upd_valid}, 32'd1);
    chk("ar_pre_branch_cnt", branch_cnt, 32'd6);
    chk("ar_pre_mispred_cnt", mispred_cnt, 32'd2);
    drive(1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h5000, 32'h5004);
    RST = 1'b1;
    #1;
    chk("ar_upd_valid", {31'b0, upd_valid}, 32'd0);
    chk("ar_branch_cnt", branch_cnt, 32'd0);
    chk("ar_mispred_cnt", mispred_cnt, 32'd0);
    chk("ar_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    chk("ar_misp_forced", {31'b0, branch_mispredict}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
